// File: rtl/sr_latch_bank_arbiter.sv
// Round-robin arbiter that owns a bank of SR latch cells: one winner per
// transaction gets a timed enable pulse on exactly one latch, mirrored into q_shadow.
module sr_latch_bank_arbiter #(
  parameter int NREQ       = 4,
  parameter int NLATCH     = 8,
  parameter int IDXW       = 3,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      op,
  input  logic [IDXW*NREQ-1:0]   idx,
  output logic [NREQ-1:0]        gnt,
  output logic                   lat_en,
  output logic [NLATCH-1:0]      lat_s,
  output logic [NLATCH-1:0]      lat_r,
  output logic [NLATCH-1:0]      q_shadow,
  output logic                   busy,
  output logic                   err,
  input  logic                   err_clr
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CNTW = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              lat_en_q, lat_en_d;
  logic [NLATCH-1:0] lat_s_q, lat_s_d;
  logic [NLATCH-1:0] lat_r_q, lat_r_d;
  logic [NLATCH-1:0] q_shadow_q, q_shadow_d;
  logic              err_q, err_d;

  logic              found;
  logic [PTRW-1:0]   win;
  int                cand;
  logic [1:0]        sel_op;
  logic [IDXW-1:0]   sel_idx;
  logic              op_set, op_clr, idx_ok, err_set;
  logic [NLATCH-1:0] sel_onehot;

  // Winner search: first requester at or above ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = PTRW'(cand);
      end
    end
  end

  always_comb begin
    sel_op     = op[2*win +: 2];
    sel_idx    = idx[IDXW*win +: IDXW];
    op_set     = (sel_op == 2'b01);
    op_clr     = (sel_op == 2'b10);
    idx_ok     = (int'(sel_idx) < NLATCH);
    sel_onehot = NLATCH'(1) << sel_idx;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    lat_en_d   = lat_en_q;
    lat_s_d    = lat_s_q;
    lat_r_d    = lat_r_q;
    q_shadow_d = q_shadow_q;
    err_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gnt_d = NREQ'(1) << win;
          ptr_d = (win == PTRW'(NREQ - 1)) ? '0 : win + PTRW'(1);
          if ((op_set || op_clr) && idx_ok) begin
            state_d  = ST_DRIVE;
            cnt_d    = CNTW'(PULSE_CYC - 1);
            lat_en_d = 1'b1;
            lat_s_d  = op_set ? sel_onehot : '0;
            lat_r_d  = op_clr ? sel_onehot : '0;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          // The drive vectors still hold the target bit and direction here.
          q_shadow_d = (q_shadow_q | lat_s_q) & ~lat_r_q;
          lat_en_d   = 1'b0;
          lat_s_d    = '0;
          lat_r_d    = '0;
          if (SETTLE_CYC > 0) begin
            state_d = ST_SETTLE;
            cnt_d   = (SETTLE_CYC > 0) ? CNTW'(SETTLE_CYC - 1) : '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNTW'(1);
      end
      default: begin
        state_d  = ST_IDLE;
        lat_en_d = 1'b0;
        lat_s_d  = '0;
        lat_r_d  = '0;
      end
    endcase

    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      lat_en_q   <= 1'b0;
      lat_s_q    <= '0;
      lat_r_q    <= '0;
      q_shadow_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      lat_en_q   <= lat_en_d;
      lat_s_q    <= lat_s_d;
      lat_r_q    <= lat_r_d;
      q_shadow_q <= q_shadow_d;
      err_q      <= err_d;
    end
  end

  assign gnt      = gnt_q;
  assign lat_en   = lat_en_q;
  assign lat_s    = lat_s_q;
  assign lat_r    = lat_r_q;
  assign q_shadow = q_shadow_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;

endmodule

// File: tb/tb_sr_latch_bank_arbiter.sv
// Bench for sr_latch_bank_arbiter: a transaction-schedule model checked every
// cycle, plus hand-computed literal checks of the directed scenarios.
module tb_sr_latch_bank_arbiter;
  localparam int NREQ = 4, NLATCH = 8, IDXW = 3, PULSE_CYC = 2, SETTLE_CYC = 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [2*NREQ-1:0]    op = '0;
  logic [IDXW*NREQ-1:0] idx = '0;
  logic                 err_clr = 1'b0;
  logic [NREQ-1:0]      gnt;
  logic                 lat_en, busy, err;
  logic [NLATCH-1:0]    lat_s, lat_r, q_shadow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int glog[$];
  int gcyc[$];

  sr_latch_bank_arbiter #(.NREQ(NREQ), .NLATCH(NLATCH), .IDXW(IDXW),
    .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx), .gnt(gnt),
    .lat_en(lat_en), .lat_s(lat_s), .lat_r(lat_r), .q_shadow(q_shadow),
    .busy(busy), .err(err), .err_clr(err_clr));

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs for one clock cycle
  typedef struct {
    logic [NREQ-1:0]   gnt;
    logic              en;
    logic [NLATCH-1:0] s;
    logic [NLATCH-1:0] r;
    logic              busy;
    logic              idle;
    logic              last;
    logic [NLATCH-1:0] new_sh;
  } frame_t;

  frame_t            fq[$];
  frame_t            cur, idle_f, f;
  int                m_ptr, m_w;
  logic [NLATCH-1:0] m_shadow, bitv;
  logic              m_err, m_illegal;
  logic [1:0]        m_op;
  logic [IDXW-1:0]   m_idx;

  initial begin
    idle_f = '{gnt: '0, en: 1'b0, s: '0, r: '0, busy: 1'b0, idle: 1'b1, last: 1'b0, new_sh: '0};
    cur = idle_f;
  end

  // Model: when idle, a request turns into a schedule of per-cycle frames.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      cur = idle_f;
      m_ptr = 0; m_shadow = '0; m_err = 1'b0;
    end else begin
      m_illegal = 1'b0;
      if (cur.last) m_shadow = cur.new_sh;
      if (cur.idle && (|req)) begin
        m_w = -1;
        for (int k = 0; k < NREQ; k++)
          if (m_w < 0 && req[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
        m_ptr = (m_w + 1) % NREQ;
        m_op  = op[2*m_w +: 2];
        m_idx = idx[IDXW*m_w +: IDXW];
        if ((m_op == 2'b01 || m_op == 2'b10) && int'(m_idx) < NLATCH) begin
          bitv = '0;
          bitv[m_idx] = 1'b1;
          for (int p = 0; p < PULSE_CYC; p++) begin
            f = idle_f;
            f.gnt = (p == 0) ? (NREQ'(1) << m_w) : '0;
            f.en = 1'b1; f.busy = 1'b1; f.idle = 1'b0;
            f.s = (m_op == 2'b01) ? bitv : '0;
            f.r = (m_op == 2'b10) ? bitv : '0;
            f.last = (p == PULSE_CYC - 1);
            f.new_sh = (m_op == 2'b01) ? (m_shadow | bitv) : (m_shadow & ~bitv);
            fq.push_back(f);
          end
          for (int p = 0; p < SETTLE_CYC; p++) begin
            f = idle_f;
            f.busy = 1'b1; f.idle = 1'b0;
            fq.push_back(f);
          end
        end else begin
          m_illegal = 1'b1;
          f = idle_f;
          f.gnt = NREQ'(1) << m_w;
          fq.push_back(f);
        end
      end
      if (m_illegal) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      cur = (fq.size() > 0) ? fq.pop_front() : idle_f;
    end
  end

  // Per-cycle compare against the model, plus drive invariants.
  always @(negedge clk) begin
    chk("gnt", 32'(gnt), 32'(cur.gnt));
    chk("lat_en", 32'(lat_en), 32'(cur.en));
    chk("lat_s", 32'(lat_s), 32'(cur.s));
    chk("lat_r", 32'(lat_r), 32'(cur.r));
    chk("busy", 32'(busy), 32'(cur.busy));
    chk("q_shadow", 32'(q_shadow), 32'(m_shadow));
    chk("err", 32'(err), 32'(m_err));
    chk("inv_s_and_r", 32'(lat_s & lat_r), 32'd0);
    chk("inv_onehot", 32'($countones(lat_s | lat_r) <= 1), 32'd1);
    chk("inv_idle_drive", 32'(!lat_en && ((lat_s | lat_r) != '0)), 32'd0);
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) begin
        glog.push_back(i);
        gcyc.push_back(cyc);
        req[i] = 1'b0;
      end
  endtask

  task automatic post(input int i, input logic [1:0] o, input logic [IDXW-1:0] x);
    req[i] = 1'b1;
    op[2*i +: 2] = o;
    idx[IDXW*i +: IDXW] = x;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; err_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    glog.delete(); gcyc.delete();
  endtask

  task automatic wait_grants(input int n, input int budget, input string name);
    int t = 0;
    while (glog.size() < n && t < budget) begin tick(); t++; end
    chk({name, "_timeout"}, 32'(glog.size() >= n), 32'd1);
  endtask

  initial begin
    // Test 1: reset state, then one set on idx 5
    tick(); tick();
    chk("rst_lat_en", 32'(lat_en), 32'd0);
    chk("rst_q_shadow", 32'(q_shadow), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    do_reset();
    post(0, 2'b01, 3'd5);
    tick();
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_lat_s", 32'(lat_s), 32'h20);
    chk("t1_lat_en", 32'(lat_en), 32'd1);
    tick();
    chk("t1_gnt_once", 32'(gnt), 32'h0);
    chk("t1_lat_s2", 32'(lat_s), 32'h20);
    tick();
    chk("t1_settle_en", 32'(lat_en), 32'd0);
    chk("t1_settle_busy", 32'(busy), 32'd1);
    chk("t1_shadow", 32'(q_shadow), 32'h20);
    tick();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Test 2: four simultaneous sets, ptr=0
    do_reset();
    for (int i = 0; i < NREQ; i++) post(i, 2'b01, IDXW'(i));
    wait_grants(4, 40, "t2");
    for (int i = 0; i < 4 && i < glog.size(); i++) chk("t2_order", 32'(glog[i]), 32'(i));
    for (int i = 1; i < 4 && i < gcyc.size(); i++) chk("t2_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd4);
    repeat (4) tick();
    chk("t2_shadow", 32'(q_shadow), 32'h0F);

    // Test 3: round-robin wrap after requester 2
    do_reset();
    post(2, 2'b01, 3'd6);
    wait_grants(1, 10, "t3a");
    post(0, 2'b01, 3'd1);
    post(2, 2'b10, 3'd6);
    wait_grants(3, 30, "t3b");
    if (glog.size() >= 3) begin
      chk("t3_first", 32'(glog[0]), 32'd2);
      chk("t3_wrap", 32'(glog[1]), 32'd0);
      chk("t3_then2", 32'(glog[2]), 32'd2);
    end
    repeat (4) tick();
    chk("t3_shadow", 32'(q_shadow), 32'h02);

    // Test 4: illegal op, legal clear, err_clr, set-beats-clear
    do_reset();
    post(0, 2'b01, 3'd0);
    repeat (5) tick();
    post(1, 2'b11, 3'd2);
    tick();
    chk("t4_ill_gnt", 32'(gnt), 32'h2);
    chk("t4_ill_err", 32'(err), 32'd1);
    chk("t4_ill_en", 32'(lat_en), 32'd0);
    post(0, 2'b10, 3'd0);
    tick();
    chk("t4_clr_gnt", 32'(gnt), 32'h1);
    chk("t4_clr_r", 32'(lat_r), 32'h01);
    chk("t4_clr_s", 32'(lat_s), 32'h00);
    repeat (3) tick();
    chk("t4_clr_shadow", 32'(q_shadow), 32'h00);
    chk("t4_err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_err_cleared", 32'(err), 32'd0);
    post(3, 2'b00, 3'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_set_wins", 32'(err), 32'd1);
    tick();

    // Test 5: reset during the second DRIVE cycle
    do_reset();
    post(0, 2'b01, 3'd4);
    tick();
    tick();
    chk("t5_drive2_en", 32'(lat_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_abort_en", 32'(lat_en), 32'd0);
    chk("t5_abort_s", 32'(lat_s), 32'd0);
    chk("t5_abort_busy", 32'(busy), 32'd0);
    chk("t5_abort_shadow", 32'(q_shadow), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    glog.delete(); gcyc.delete();
    post(2, 2'b01, 3'd2);
    post(1, 2'b01, 3'd1);
    wait_grants(2, 20, "t5");
    if (glog.size() >= 2) begin
      chk("t5_from_ptr0", 32'(glog[0]), 32'd1);
      chk("t5_next", 32'(glog[1]), 32'd2);
    end
    repeat (4) tick();
    chk("t5_shadow", 32'(q_shadow), 32'h06);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
